// File: rtl/mux_scan_nto1_pkg.sv
// Shared definitions for the scanning N:1 multiplexer: FSM state encoding and a
// ceil(log2) helper for sizing select and dwell counters.
package mux_scan_nto1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_nto1_comb.sv
// Pure combinational WIDTH x CHANNELS selector. An out-of-range select yields
// zero data and raises o_oor.
module mux_scan_nto1_comb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS*WIDTH-1:0] i_din,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_dout,
    output logic                      o_oor
);

    always_comb begin
        o_dout = '0;
        o_oor  = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_dout = i_din[k*WIDTH +: WIDTH];
                o_oor  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-channel multiplexer with manual select and round-robin scan
// modes, producing a flagged sample stream (valid, wrap, sel_err).
module mux_scan_nto1
    import mux_scan_nto1_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid,
    output logic                      wrap,
    output logic                      sel_err,
    output state_t                    dbg_state
);

    localparam int              DW_W    = (DWELL > 1) ? clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

    state_t            r_state;
    state_t            w_next;
    logic [SEL_W-1:0]  r_idx;
    logic [DW_W-1:0]   r_dw;
    logic [SEL_W-1:0]  w_idx;
    logic [DW_W-1:0]   w_dw;
    logic [SEL_W-1:0]  w_sel;
    logic              w_last_ch;
    logic              w_last_dw;
    logic [WIDTH-1:0]  w_mux_dout;
    logic              w_oor;
    logic [WIDTH-1:0]  r_dout;
    logic [SEL_W-1:0]  r_sel_out;
    logic              r_valid;
    logic              r_wrap;
    logic              r_sel_err;

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = ST_IDLE;
        end else if (mode) begin
            w_next = ST_SCAN;
        end else begin
            w_next = ST_MAN;
        end
    end

    // Scan position only survives while staying in SCAN; any entry starts at channel 0.
    assign w_idx     = (r_state == ST_SCAN) ? r_idx : '0;
    assign w_dw      = (r_state == ST_SCAN) ? r_dw  : '0;
    assign w_last_ch = (w_idx == LAST_CH);
    assign w_last_dw = (w_dw == LAST_DW);
    assign w_sel     = (w_next == ST_MAN) ? sel_in : w_idx;

    mux_scan_nto1_comb #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .SEL_W   (SEL_W)
    ) u_sel (
        .i_din (din),
        .i_sel (w_sel),
        .o_dout(w_mux_dout),
        .o_oor (w_oor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_dw      <= '0;
            r_dout    <= '0;
            r_sel_out <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (w_next)
                ST_MAN: begin
                    r_dout    <= w_mux_dout;
                    r_sel_out <= sel_in;
                    r_valid   <= 1'b1;
                    r_wrap    <= 1'b0;
                    r_sel_err <= w_oor;
                    r_idx     <= '0;
                    r_dw      <= '0;
                end
                ST_SCAN: begin
                    r_dout    <= w_mux_dout;
                    r_sel_out <= w_idx;
                    r_valid   <= 1'b1;
                    r_wrap    <= w_last_ch && w_last_dw;
                    r_sel_err <= 1'b0;
                    if (w_last_dw) begin
                        r_dw  <= '0;
                        r_idx <= w_last_ch ? '0 : w_idx + SEL_W'(1);
                    end else begin
                        r_dw  <= w_dw + DW_W'(1);
                        r_idx <= w_idx;
                    end
                end
                default: begin
                    r_valid   <= 1'b0;
                    r_wrap    <= 1'b0;
                    r_sel_err <= 1'b0;
                    r_idx     <= '0;
                    r_dw      <= '0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign sel_out   = r_sel_out;
    assign valid     = r_valid;
    assign wrap      = r_wrap;
    assign sel_err   = r_sel_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1: directed vector table, randomized run against a
// behavioural model, async reset checks and a 3-channel out-of-range instance.
module tb_mux_scan_nto1;
    import mux_scan_nto1_pkg::*;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int DW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance A: 4 channels ----------------
    logic          en = 1'b0, mode = 1'b0;
    logic [1:0]    sel_in = '0;
    logic [31:0]   din = 32'h44332211;
    logic [7:0]    dout;
    logic [1:0]    sel_out;
    logic          valid, wrap, sel_err;
    state_t        dbg_state;

    mux_scan_nto1 #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .din(din),
        .dout(dout), .sel_out(sel_out), .valid(valid), .wrap(wrap),
        .sel_err(sel_err), .dbg_state(dbg_state)
    );

    // ---------------- instance B: 3 channels ----------------
    logic          en_b = 1'b0, mode_b = 1'b0;
    logic [1:0]    sel_b = '0;
    logic [23:0]   din_b = 24'h332211;
    logic [7:0]    dout_b;
    logic [1:0]    sel_out_b;
    logic          valid_b, wrap_b, err_b;
    state_t        dbg_b;

    mux_scan_nto1 #(.WIDTH(W), .CHANNELS(3), .DWELL(DW)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel_in(sel_b), .din(din_b),
        .dout(dout_b), .sel_out(sel_out_b), .valid(valid_b), .wrap(wrap_b),
        .sel_err(err_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [7:0] e_dout;
        logic [1:0] e_sel;
        logic       e_valid;
        logic       e_wrap;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic e, input logic m, input logic [1:0] s,
                                    input logic [7:0] d, input logic [1:0] so,
                                    input logic v, input logic wr, input logic er);
        vec_t x;
        x.en = e; x.mode = m; x.sel = s; x.e_dout = d; x.e_sel = so;
        x.e_valid = v; x.e_wrap = wr; x.e_err = er;
        vecs.push_back(x);
    endfunction

    // ---------------- behavioural model (instance A) ----------------
    logic [7:0] m_dout;
    logic [1:0] m_sel;
    logic       m_valid, m_wrap, m_err;
    bit         m_scan;
    int         m_k;

    function automatic void model_reset();
        m_dout = '0; m_sel = '0; m_valid = 0; m_wrap = 0; m_err = 0;
        m_scan = 0; m_k = 0;
    endfunction

    // m_k counts samples since scan entry; channel and wrap follow from it directly.
    function automatic void model_step(input logic e, input logic m, input logic [1:0] s,
                                       input logic [31:0] d);
        int ch;
        if (!e) begin
            m_valid = 0; m_wrap = 0; m_err = 0; m_scan = 0;
        end else if (!m) begin
            m_scan  = 0;
            m_sel   = s;
            m_valid = 1; m_wrap = 0;
            m_err   = (int'(s) >= CH);
            m_dout  = m_err ? 8'h00 : d[int'(s)*W +: W];
        end else begin
            if (!m_scan) m_k = 0;
            m_scan  = 1;
            ch      = (m_k / DW) % CH;
            m_dout  = d[ch*W +: W];
            m_sel   = 2'(ch);
            m_valid = 1; m_err = 0;
            m_wrap  = ((m_k % (CH*DW)) == CH*DW - 1);
            m_k++;
        end
    endfunction

    task automatic check_reset_now(input string tag);
        check({tag, " dout"}, 32'(dout), 0);
        check({tag, " sel_out"}, 32'(sel_out), 0);
        check({tag, " valid"}, 32'(valid), 0);
        check({tag, " wrap"}, 32'(wrap), 0);
        check({tag, " sel_err"}, 32'(sel_err), 0);
        check({tag, " b_dout"}, 32'(dout_b), 0);
        check({tag, " b_sel_err"}, 32'(err_b), 0);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_now(tag);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic e, m;
        logic [1:0] s;
        logic [31:0] d;

        // Reset state
        step();
        step();
        check_reset_now("por");
        rst = 1'b0;

        // Table: idle, manual, full scan period, mode switch, enable drop
        add_vec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        add_vec(1, 0, 2, 8'h33, 2, 1, 0, 0);
        add_vec(1, 0, 0, 8'h11, 0, 1, 0, 0);
        for (int k = 0; k < 16; k++)
            add_vec(1, 1, 0, 8'(8'h11 * (k/4 + 1)), 2'(k/4), 1, (k == 15), 0);
        add_vec(1, 1, 0, 8'h11, 0, 1, 0, 0);
        for (int k = 17; k < 26; k++)
            add_vec(1, 1, 0, 8'(8'h11 * (k/4 - 3)), 2'(k/4 - 4), 1, 0, 0);
        add_vec(1, 0, 3, 8'h44, 3, 1, 0, 0);
        add_vec(1, 1, 3, 8'h11, 0, 1, 0, 0);
        add_vec(1, 1, 3, 8'h11, 0, 1, 0, 0);
        add_vec(0, 1, 3, 8'h11, 0, 0, 0, 0);
        add_vec(0, 1, 3, 8'h11, 0, 0, 0, 0);
        add_vec(1, 1, 3, 8'h11, 0, 1, 0, 0);
        add_vec(1, 1, 3, 8'h11, 0, 1, 0, 0);
        add_vec(1, 1, 3, 8'h11, 0, 1, 0, 0);
        add_vec(1, 1, 3, 8'h11, 0, 1, 0, 0);
        add_vec(1, 1, 3, 8'h22, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; sel_in = vecs[i].sel;
            step();
            check($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].e_dout));
            check($sformatf("vec%0d sel_out", i), 32'(sel_out), 32'(vecs[i].e_sel));
            check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
            check($sformatf("vec%0d sel_err", i), 32'(sel_err), 32'(vecs[i].e_err));
        end

        // Async reset mid-cycle while outputs are non-zero
        mid_cycle_reset("async_rst");

        // Randomized run against the model, with occasional mid-cycle resets
        e = 1; m = 1;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) m = ~m;
            s = 2'($urandom_range(0, 3));
            d = $urandom;
            en = e; mode = m; sel_in = s; din = d;
            model_step(e, m, s, d);
            step();
            check($sformatf("rnd%0d dout", i), 32'(dout), 32'(m_dout));
            check($sformatf("rnd%0d sel_out", i), 32'(sel_out), 32'(m_sel));
            check($sformatf("rnd%0d valid", i), 32'(valid), 32'(m_valid));
            check($sformatf("rnd%0d wrap", i), 32'(wrap), 32'(m_wrap));
            check($sformatf("rnd%0d sel_err", i), 32'(sel_err), 32'(m_err));
            if ($urandom_range(0, 59) == 0) mid_cycle_reset($sformatf("rnd%0d rst", i));
        end
        en = 0;

        // Three-channel instance: out-of-range manual select
        en_b = 1; mode_b = 0; sel_b = 3;
        step();
        check("b oor dout", 32'(dout_b), 0);
        check("b oor sel_err", 32'(err_b), 1);
        check("b oor valid", 32'(valid_b), 1);
        check("b oor wrap", 32'(wrap_b), 0);
        check("b oor sel_out", 32'(sel_out_b), 3);
        sel_b = 1;
        step();
        check("b sel1 dout", 32'(dout_b), 32'h22);
        check("b sel1 sel_err", 32'(err_b), 0);
        sel_b = 3;
        step();
        check("b oor2 sel_err", 32'(err_b), 1);
        en_b = 0;
        step();
        check("b idle sel_err", 32'(err_b), 0);
        check("b idle valid", 32'(valid_b), 0);
        check("b idle dout", 32'(dout_b), 0);

        // Three-channel scan: wrap after 12 samples
        en_b = 1; mode_b = 1;
        for (int k = 0; k < 13; k++) begin
            step();
            check($sformatf("b scan%0d dout", k), 32'(dout_b), 32'(8'h11 * ((k/4) % 3 + 1)));
            check($sformatf("b scan%0d wrap", k), 32'(wrap_b), 32'(k == 11));
            check($sformatf("b scan%0d sel_err", k), 32'(err_b), 0);
        end
        en_b = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
